// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for EX: one quotient bit per cycle, signed or unsigned.
// Stalls the pipeline while busy and presents LO/HI for exactly one cycle.
module div_sequencer #(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] ZERO_Q = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              annul,
    output logic              stallreq_for_ex,
    output logic              result_valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div_by_zero
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DIV_ON, DIV_END} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] dvd, dsr, part, quo;
    logic              neg_q, neg_r;

    logic              accept, last;
    logic              sign_a, sign_b;
    logic [DATA_W-1:0] mag_a, mag_b;
    logic [DATA_W:0]   shifted, diff;
    logic              q_bit;
    logic [DATA_W-1:0] part_nxt, quo_nxt, done_q, done_r;

    assign accept = (state == IDLE) && start && !annul;
    assign last   = (cnt == CNT_W'(DATA_W - 1));
    assign sign_a = signed_op & op_a[DATA_W-1];
    assign sign_b = signed_op & op_b[DATA_W-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -op_b : op_b;

    // Partial remainder is always < divisor, so a set carry-out bit of the
    // shifted value can never make the subtraction go negative.
    assign shifted  = {part, dvd[DATA_W-1]};
    assign diff     = shifted - {1'b0, dsr};
    assign q_bit    = !diff[DATA_W];
    assign part_nxt = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    assign quo_nxt  = {quo[DATA_W-2:0], q_bit};
    assign done_q   = neg_q ? -quo_nxt  : quo_nxt;
    assign done_r   = neg_r ? -part_nxt : part_nxt;

    always_comb begin
        state_nxt       = state;
        stallreq_for_ex = 1'b0;
        result_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stallreq_for_ex = 1'b1;
                    state_nxt       = (op_b == '0) ? DIV_END : DIV_ON;
                end
            end
            DIV_ON: begin
                stallreq_for_ex = 1'b1;
                if (last) state_nxt = DIV_END;
            end
            DIV_END: begin
                result_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (annul) begin
            stallreq_for_ex = 1'b0;
            result_valid    = 1'b0;
            state_nxt       = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            part        <= '0;
            quo         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (annul) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: if (accept) begin
                        cnt   <= '0;
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        if (op_b == '0) begin
                            quotient    <= ZERO_Q;
                            remainder   <= op_a;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd  <= mag_a;
                            dsr  <= mag_b;
                            part <= '0;
                            quo  <= '0;
                        end
                    end
                    DIV_ON: begin
                        dvd  <= dvd << 1;
                        part <= part_nxt;
                        quo  <= quo_nxt;
                        cnt  <= cnt + CNT_W'(1);
                        if (last) begin
                            cnt         <= '0;
                            quotient    <= done_q;
                            remainder   <= done_r;
                            div_by_zero <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed and small random checks of div_sequencer timing, signed fix-up and abort paths.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        annul = 1'b0;
    logic        stallreq_for_ex, result_valid, div_by_zero;
    logic [31:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    div_sequencer #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .op_a(op_a), .op_b(op_b), .annul(annul),
        .stallreq_for_ex(stallreq_for_ex), .result_valid(result_valid),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference: language division plus the two architectural special cases.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic d);
        logic signed [31:0] sa, sb;
        sa = a; sb = b; d = 1'b0;
        if (b == 0) begin
            q = 32'hFFFF_FFFF; r = a; d = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 0;
        end else if (s) begin
            q = sa / sb; r = sa % sb;
        end else begin
            q = a / b; r = a % b;
        end
    endtask

    // Start an op at the next cycle, scramble (or hold) inputs while busy, and check the result cycle.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er,
                           input logic ed, input int lat, input bit hold,
                           input logic [31:0] na, input logic [31:0] nb);
        logic early, stall_bad;
        @(negedge clk);
        annul = 0; start = 1; op_a = a; op_b = b; signed_op = s;
        #1 chk({tag, "_stall_T"}, stallreq_for_ex, 1);
        early = 0; stall_bad = 0;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            if (hold) begin
                op_a = na; op_b = nb; signed_op = 0;
            end else begin
                start = 0; op_a = $urandom; op_b = $urandom; signed_op = ~s;
            end
            #1;
            if (result_valid !== 1'b0) early = 1;
            if (stallreq_for_ex !== 1'b1) stall_bad = 1;
        end
        @(negedge clk);
        if (hold) begin
            op_a = na; op_b = nb; signed_op = 0;
        end else begin
            start = 0;
        end
        #1;
        chk({tag, "_early_valid"}, early, 0);
        chk({tag, "_busy_stall"}, stall_bad, 0);
        chk({tag, "_valid"}, result_valid, 1);
        chk({tag, "_end_stall"}, stallreq_for_ex, 0);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, ed);
        if (!hold) begin
            @(negedge clk);
            #1 chk({tag, "_valid_drop"}, result_valid, 0);
        end
    endtask

    initial begin
        logic [31:0] ra, rb, mq, mr;
        logic        rs, md, seen;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", result_valid, 0);
        chk("rst_stall", stallreq_for_ex, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk); rst = 0;

        run_div("u7_2",  32'd7,          32'd2,          0, 32'd3,          32'd1,          0, 33, 0, 0, 0);
        run_div("sm7_2", 32'hFFFF_FFF9,  32'd2,          1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 33, 0, 0, 0);
        run_div("s7_m2", 32'd7,          32'hFFFF_FFFE,  1, 32'hFFFF_FFFD,  32'd1,          0, 33, 0, 0, 0);
        run_div("s_ovf", 32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000,  32'd0,          0, 33, 0, 0, 0);
        run_div("u_ovf", 32'h8000_0000,  32'hFFFF_FFFF,  0, 32'd0,          32'h8000_0000,  0, 33, 0, 0, 0);
        run_div("dbz5",  32'd5,          32'd0,          0, 32'hFFFF_FFFF,  32'd5,          1, 1,  0, 0, 0);
        run_div("u_max", 32'hFFFF_FFFF,  32'd1,          0, 32'hFFFF_FFFF,  32'd0,          0, 33, 0, 0, 0);

        // annul at T+10 aborts; new op accepted at T+11
        @(negedge clk);
        start = 1; op_a = 20; op_b = 3; signed_op = 0;
        seen = 0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clk); start = 0; #1;
            if (result_valid !== 1'b0) seen = 1;
        end
        @(negedge clk); annul = 1; #1;
        chk("annul_stall", stallreq_for_ex, 0);
        chk("annul_valid", result_valid | seen, 0);
        run_div("annul_resume", 32'd9, 32'd3, 0, 32'd3, 32'd0, 0, 33, 0, 0, 0);

        // rst at T+5 aborts and clears outputs
        @(negedge clk);
        start = 1; op_a = 50; op_b = 7; signed_op = 0;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); start = 0;
        end
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; #1;
        chk("rstab_valid", result_valid, 0);
        chk("rstab_stall", stallreq_for_ex, 0);
        chk("rstab_q", quotient, 0);
        chk("rstab_r", remainder, 0);
        run_div("rst_resume", 32'd9, 32'd3, 0, 32'd3, 32'd0, 0, 33, 0, 0, 0);

        // start together with annul in IDLE is never accepted
        @(negedge clk);
        start = 1; annul = 1; op_a = 9; op_b = 3; signed_op = 0;
        #1 chk("annul_start_stall", stallreq_for_ex, 0);
        @(negedge clk); start = 0; annul = 0;
        seen = 0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clk); #1;
            if (result_valid !== 1'b0 || stallreq_for_ex !== 1'b0) seen = 1;
        end
        chk("annul_start_quiet", seen, 0);

        // start held through DIV_END: second op accepted the next cycle
        run_div("b2b_1", 32'd7,   32'd2, 0, 32'd3,  32'd1, 0, 33, 1, 32'd100, 32'd7);
        run_div("b2b_2", 32'd100, 32'd7, 0, 32'd14, 32'd2, 0, 33, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            rs = 1'($urandom);
            ra = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 9);
                2:       rb = -$urandom_range(1, 9);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            model(ra, rb, rs, mq, mr, md);
            run_div("rand", ra, rb, rs, mq, mr, md, (rb == 0) ? 1 : 33, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
